// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of {instr, pc} pairs between fetch and decode.
// Optional FETCHQ_BYPASS_EN: empty queue forwards the input pair combinationally.
module fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_instr,
  input  logic [DATA_WIDTH-1:0]      in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_instr,
  output logic [DATA_WIDTH-1:0]      out_pc,
  output logic [DATA_WIDTH-1:0]      out_pcplus4,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];

  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic byp;
  logic wr_en;
  logic rd_en;

  logic [DATA_WIDTH-1:0] head_instr;
  logic [DATA_WIDTH-1:0] head_pc;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) &&
                 (wr_ptr[PW] != rd_ptr[PW]);

  // in_ready ignores out_ready: a full queue never takes a push
  assign in_ready = !full;
  assign push     = in_valid && in_ready;

`ifdef FETCHQ_BYPASS_EN
  assign byp = empty && !flush && in_valid;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = (!empty && !flush) || byp;
  assign pop       = out_valid && out_ready;

  // A bypassed entry taken the same cycle is never stored
  assign wr_en = push && !(byp && out_ready);
  assign rd_en = pop && !byp;

  assign head_instr = byp ? in_instr : mem_instr[rd_ptr[PW-1:0]];
  assign head_pc    = byp ? in_pc    : mem_pc[rd_ptr[PW-1:0]];

  assign out_instr   = out_valid ? head_instr : NOP;
  assign out_pc      = out_valid ? head_pc : '0;
  assign out_pcplus4 = out_pc + DATA_WIDTH'(4);

  assign count = wr_ptr - rd_ptr;

  // Pointer update; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem_instr[wr_ptr[PW-1:0]] <= in_instr;
      mem_pc[wr_ptr[PW-1:0]]    <= in_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue (DEPTH=4, DATA_WIDTH=32).
// Expectations follow FETCHQ_BYPASS_EN when it is defined for the build.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [2:0]  count;

  int checks;
  int errors;

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_pcplus4(out_pcplus4),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    in_pc    = 32'h0000_0500;
    in_instr = 32'h1234_5678;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd1) begin
      errors++;
      $display("FAIL pre_rst got v=%b c=%0d want v=1 c=1", out_valid, count);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL async_rst got v=%b r=%b c=%0d want 0 1 0",
               out_valid, in_ready, count);
    end
    checks++;
    if (out_instr !== 32'h0000_0013 || out_pc !== 32'h0 ||
        out_pcplus4 !== 32'h4) begin
      errors++;
      $display("FAIL rst_outs got i=%h p=%h p4=%h want 00000013 0 4",
               out_instr, out_pc, out_pcplus4);
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(i * 4);
      in_instr = 32'h0050_0093 + 32'(i << 20);
      tick();
      checks++;
      if (count !== 3'(i + 1)) begin
        errors++;
        $display("FAIL fill_count got %0d want %0d", count, i + 1);
      end
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got %b want 0", in_ready);
    end
    in_pc    = 32'h10;
    in_instr = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_ready got %b want 0", in_ready);
    end
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL fifth_push got count %0d want 4", count);
    end
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) ||
          out_pcplus4 !== 32'(i * 4 + 4) ||
          out_instr !== 32'h0050_0093 + 32'(i << 20)) begin
        errors++;
        $display("FAIL drain_%0d got v=%b pc=%h p4=%h i=%h", i,
                 out_valid, out_pc, out_pcplus4, out_instr);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL drain_end got v=%b c=%0d want 0 0", out_valid, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] base;
    int bad;
    base = 32'h0000_1000;
    bad  = 0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_pc     = base;
    in_instr  = 32'hA000_0000 | base;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_pc    = base + 32'((k + 1) * 4);
      in_instr = 32'hA000_0000 | in_pc;
      #1;
      if (out_valid !== 1'b1 || out_pc !== base + 32'(k * 4) ||
          out_instr !== (32'hA000_0000 | (base + 32'(k * 4)))) begin
        bad++;
        $display("FAIL stream_head_%0d got v=%b pc=%h i=%h", k,
                 out_valid, out_pc, out_instr);
      end
      tick();
      if (count !== 3'd1) begin
        bad++;
        $display("FAIL stream_count_%0d got %0d want 1", k, count);
      end
    end
    checks++;
    if (bad != 0) errors++;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_pc !== base + 32'd80) begin
      errors++;
      $display("FAIL stream_last got %h want %h", out_pc, base + 32'd80);
    end
    tick();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got c=%0d v=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h20 + 32'(i * 4);
      in_instr = 32'h0000_0033 + 32'(i << 7);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre got %0d want 3", count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pc    = 32'h100;
    in_instr = 32'h0000_0100;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_after got c=%0d v=%b want 0 0", count, out_valid);
    end
    in_valid = 1'b1;
    in_pc    = 32'h200;
    in_instr = 32'h0000_0200;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200 || count !== 3'd1) begin
      errors++;
      $display("FAIL flush_next got v=%b pc=%h c=%0d want 1 200 1",
               out_valid, out_pc, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL flush_pop got %0d want 0", count);
    end
  endtask

  task automatic test_bypass();
    in_valid  = 1'b1;
    in_pc     = 32'h40;
    in_instr  = 32'h0000_0040;
    out_ready = 1'b1;
    #1;
    checks++;
`ifdef FETCHQ_BYPASS_EN
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_pcplus4 !== 32'h44) begin
      errors++;
      $display("FAIL bypass_out got v=%b pc=%h p4=%h want 1 40 44",
               out_valid, out_pc, out_pcplus4);
    end
`else
    if (out_valid !== 1'b0 || out_pc !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_out got v=%b pc=%h want 0 0", out_valid, out_pc);
    end
`endif
    tick();
    in_valid = 1'b0;
    checks++;
`ifdef FETCHQ_BYPASS_EN
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_count got %0d want 0", count);
    end
`else
    if (count !== 3'd1 || out_pc !== 32'h40) begin
      errors++;
      $display("FAIL nobypass_count got c=%0d pc=%h want 1 40", count, out_pc);
    end
`endif
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_end got %0d want 0", count);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    tick();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
